// File: rtl/dm_split_interface_pkg.sv
// Shared loopyV data-memory types: funct3 encodings, interface FSM states
// and the funct3-to-access-size decode.
package loopyV_data_types;

   localparam logic [2:0] FUNCT3_BYTE       = 3'b000;
   localparam logic [2:0] FUNCT3_HALFWORD   = 3'b001;
   localparam logic [2:0] FUNCT3_WORD       = 3'b010;
   localparam logic [2:0] FUNCT3_BYTE_U     = 3'b100;
   localparam logic [2:0] FUNCT3_HALFWORD_U = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      REQ0,
      RSP0,
      REQ1,
      RSP1,
      DONE
   } dm_state_t;

   // Access size in bytes; 0 marks an illegal funct3.
   function automatic logic [2:0] dm_access_size(input logic [2:0] funct3);
      case (funct3)
         FUNCT3_BYTE, FUNCT3_BYTE_U:         return 3'd1;
         FUNCT3_HALFWORD, FUNCT3_HALFWORD_U: return 3'd2;
         FUNCT3_WORD:                        return 3'd4;
         default:                            return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/dm_split_interface_if.sv
// Core request/response and data-bus signals of the data-memory interface.
// slave = the interface block, master = core plus bus side.
interface dm_split_interface_if #(parameter int unsigned BUS_BYTES = 4);

   logic                     reqValid;
   logic                     reqReady;
   logic                     reqWrite;
   logic [2:0]               reqFunct3;
   logic [31:0]              reqAddr;
   logic [31:0]              reqWData;
   logic                     respValid;
   logic                     respErr;
   logic [31:0]              respData;
   logic [31:0]              dataBusAddr;
   logic                     dataBusReadEn;
   logic                     dataBusWriteEn;
   logic [BUS_BYTES-1:0]     dataBusWriteMask;
   logic [8*BUS_BYTES-1:0]   dataBusWriteData;
   logic                     dataBusGnt;
   logic                     dataBusRValid;
   logic [8*BUS_BYTES-1:0]   dataBusReadData;

   modport slave (
      input  reqValid, reqWrite, reqFunct3, reqAddr, reqWData,
             dataBusGnt, dataBusRValid, dataBusReadData,
      output reqReady, respValid, respErr, respData,
             dataBusAddr, dataBusReadEn, dataBusWriteEn,
             dataBusWriteMask, dataBusWriteData
   );

   modport master (
      output reqValid, reqWrite, reqFunct3, reqAddr, reqWData,
             dataBusGnt, dataBusRValid, dataBusReadData,
      input  reqReady, respValid, respErr, respData,
             dataBusAddr, dataBusReadEn, dataBusWriteEn,
             dataBusWriteMask, dataBusWriteData
   );

endinterface

// File: rtl/dm_split_interface_lane_align.sv
// Combinational lane shaping over a two-beat window: store mask/data
// placement and load extraction with sign/zero extension.
module dm_lane_align
   import loopyV_data_types::*;
#(
   parameter int unsigned BUS_BYTES = 4
) (
   input  logic [2:0]                   funct3,
   input  logic [$clog2(BUS_BYTES)-1:0] offset,
   input  logic [31:0]                  wdata,
   input  logic [16*BUS_BYTES-1:0]      rdata,
   output logic [2*BUS_BYTES-1:0]       mask,
   output logic [16*BUS_BYTES-1:0]      wdata_lanes,
   output logic [31:0]                  load_data
);

   logic [3:0]  size_ones;
   logic [31:0] word;

   always_comb begin
      case (dm_access_size(funct3))
         3'd1:    size_ones = 4'b0001;
         3'd2:    size_ones = 4'b0011;
         3'd4:    size_ones = 4'b1111;
         default: size_ones = 4'b0000;
      endcase

      mask        = {{(2*BUS_BYTES-4){1'b0}}, size_ones} << offset;
      wdata_lanes = {{(16*BUS_BYTES-32){1'b0}}, wdata} << {offset, 3'b000};
      word        = 32'(rdata >> {offset, 3'b000});

      case (funct3)
         FUNCT3_BYTE:       load_data = {{24{word[7]}}, word[7:0]};
         FUNCT3_BYTE_U:     load_data = {24'd0, word[7:0]};
         FUNCT3_HALFWORD:   load_data = {{16{word[15]}}, word[15:0]};
         FUNCT3_HALFWORD_U: load_data = {16'd0, word[15:0]};
         default:           load_data = word;
      endcase
   end

endmodule

// File: rtl/dm_split_interface.sv
// loopyV data-memory interface: valid/ready core request, granted
// variable-latency bus, optional two-beat split of boundary-crossing accesses.
module dm_split_interface #(
   parameter int unsigned BUS_BYTES     = 4,
   parameter bit          MISALIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             resetN,
   dm_split_interface_if.slave dm
);

   import loopyV_data_types::*;

   localparam int unsigned OFF_W = $clog2(BUS_BYTES);
   localparam int unsigned BW    = 8 * BUS_BYTES;

   dm_state_t       state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [2:0]      funct3_q, funct3_d;
   logic            write_q, write_d;
   logic            err_q, err_d;
   logic [BW-1:0]   beat0_q, beat0_d;
   logic [BW-1:0]   beat1_q, beat1_d;

   logic [OFF_W-1:0]      offset, req_offset;
   logic [2:0]            size, req_size;
   logic                  split, req_split;
   logic [31:0]           beat0_addr;
   logic [2*BUS_BYTES-1:0] mask2;
   logic [2*BW-1:0]       wdata2;
   logic [31:0]           load_data;

   always_comb begin
      offset     = addr_q[OFF_W-1:0];
      size       = dm_access_size(funct3_q);
      split      = (32'(offset) + 32'(size)) > BUS_BYTES;
      req_offset = dm.reqAddr[OFF_W-1:0];
      req_size   = dm_access_size(dm.reqFunct3);
      req_split  = (32'(req_offset) + 32'(req_size)) > BUS_BYTES;
      beat0_addr = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
   end

   // beat1_q stays zero for unsplit loads so the shift window sees zeros.
   dm_lane_align #(.BUS_BYTES(BUS_BYTES)) u_lane_align (
      .funct3      (funct3_q),
      .offset      (offset),
      .wdata       (wdata_q),
      .rdata       ({beat1_q, beat0_q}),
      .mask        (mask2),
      .wdata_lanes (wdata2),
      .load_data   (load_data)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      write_d  = write_q;
      err_d    = err_q;
      beat0_d  = beat0_q;
      beat1_d  = beat1_q;

      dm.reqReady         = 1'b0;
      dm.respValid        = 1'b0;
      dm.respErr          = 1'b0;
      dm.respData         = '0;
      dm.dataBusAddr      = '0;
      dm.dataBusReadEn    = 1'b0;
      dm.dataBusWriteEn   = 1'b0;
      dm.dataBusWriteMask = '0;
      dm.dataBusWriteData = '0;

      case (state_q)
         IDLE: begin
            dm.reqReady = 1'b1;
            if (dm.reqValid) begin
               addr_d   = dm.reqAddr;
               wdata_d  = dm.reqWData;
               funct3_d = dm.reqFunct3;
               write_d  = dm.reqWrite;
               beat0_d  = '0;
               beat1_d  = '0;
               err_d    = (req_size == 3'd0) || (req_split && !MISALIGNED_EN);
               state_d  = err_d ? DONE : REQ0;
            end
         end
         REQ0: begin
            dm.dataBusAddr      = beat0_addr;
            dm.dataBusReadEn    = !write_q;
            dm.dataBusWriteEn   = write_q;
            dm.dataBusWriteMask = mask2[BUS_BYTES-1:0];
            dm.dataBusWriteData = wdata2[BW-1:0];
            if (dm.dataBusGnt) begin
               if (!write_q)   state_d = RSP0;
               else if (split) state_d = REQ1;
               else            state_d = DONE;
            end
         end
         RSP0: begin
            if (dm.dataBusRValid) begin
               beat0_d = dm.dataBusReadData;
               state_d = split ? REQ1 : DONE;
            end
         end
         REQ1: begin
            dm.dataBusAddr      = beat0_addr + 32'(BUS_BYTES);
            dm.dataBusReadEn    = !write_q;
            dm.dataBusWriteEn   = write_q;
            dm.dataBusWriteMask = mask2[2*BUS_BYTES-1:BUS_BYTES];
            dm.dataBusWriteData = wdata2[2*BW-1:BW];
            if (dm.dataBusGnt) state_d = write_q ? DONE : RSP1;
         end
         RSP1: begin
            if (dm.dataBusRValid) begin
               beat1_d = dm.dataBusReadData;
               state_d = DONE;
            end
         end
         DONE: begin
            dm.respValid = 1'b1;
            dm.respErr   = err_q;
            dm.respData  = (err_q || write_q) ? '0 : load_data;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         beat0_q  <= '0;
         beat1_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         write_q  <= write_d;
         err_q    <= err_d;
         beat0_q  <= beat0_d;
         beat1_q  <= beat1_d;
      end
   end

endmodule

// File: tb/tb_dm_split_interface.sv
// Bench for dm_split_interface: three configurations share one bus/core driver;
// results are checked against a byte-level reference model.
module tb_dm_split_interface;

   import loopyV_data_types::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic resetN;

   int checks = 0;
   int errors = 0;
   int sel;
   int en_b_count = 0;

   logic        req_valid, req_write, bus_gnt, bus_rvalid;
   logic [2:0]  req_f3;
   logic [31:0] req_addr, req_wdata;
   logic [63:0] bus_rdata;

   logic        v_ready, v_resp_valid, v_resp_err, v_ren, v_wen;
   logic [31:0] v_resp_data, v_addr;
   logic [7:0]  v_mask;
   logic [63:0] v_wdata;

   int          obs_beats, obs_lat;
   logic        obs_err, obs_ready0, obs_stable, obs_idle_zero, obs_en_seen;
   logic [31:0] obs_data;
   logic [31:0] obs_addr [2];
   logic [7:0]  obs_mask [2];
   logic [63:0] obs_wdata [2];
   logic        obs_wen [2];

   int          exp_beats, exp_lat;
   logic        exp_err;
   logic [31:0] exp_data;
   logic [31:0] exp_addr [2];
   logic [7:0]  exp_mask [2];
   logic [63:0] exp_wdata [2];

   // a: 4-byte bus split, b: 4-byte bus no split, c: 8-byte bus split
   dm_split_interface_if #(.BUS_BYTES(4)) if_a ();
   dm_split_interface_if #(.BUS_BYTES(4)) if_b ();
   dm_split_interface_if #(.BUS_BYTES(8)) if_c ();

   dm_split_interface #(.BUS_BYTES(4), .MISALIGNED_EN(1'b1)) dut_a (.clk(clk), .resetN(resetN), .dm(if_a));
   dm_split_interface #(.BUS_BYTES(4), .MISALIGNED_EN(1'b0)) dut_b (.clk(clk), .resetN(resetN), .dm(if_b));
   dm_split_interface #(.BUS_BYTES(8), .MISALIGNED_EN(1'b1)) dut_c (.clk(clk), .resetN(resetN), .dm(if_c));

   assign if_a.reqValid = req_valid && (sel == 0);
   assign if_b.reqValid = req_valid && (sel == 1);
   assign if_c.reqValid = req_valid && (sel == 2);
   assign if_a.reqWrite = req_write;   assign if_b.reqWrite = req_write;   assign if_c.reqWrite = req_write;
   assign if_a.reqFunct3 = req_f3;     assign if_b.reqFunct3 = req_f3;     assign if_c.reqFunct3 = req_f3;
   assign if_a.reqAddr = req_addr;     assign if_b.reqAddr = req_addr;     assign if_c.reqAddr = req_addr;
   assign if_a.reqWData = req_wdata;   assign if_b.reqWData = req_wdata;   assign if_c.reqWData = req_wdata;
   assign if_a.dataBusGnt = bus_gnt && (sel == 0);
   assign if_b.dataBusGnt = bus_gnt && (sel == 1);
   assign if_c.dataBusGnt = bus_gnt && (sel == 2);
   assign if_a.dataBusRValid = bus_rvalid && (sel == 0);
   assign if_b.dataBusRValid = bus_rvalid && (sel == 1);
   assign if_c.dataBusRValid = bus_rvalid && (sel == 2);
   assign if_a.dataBusReadData = bus_rdata[31:0];
   assign if_b.dataBusReadData = bus_rdata[31:0];
   assign if_c.dataBusReadData = bus_rdata;

   always_comb begin
      case (sel)
         0: begin
            v_ready = if_a.reqReady; v_resp_valid = if_a.respValid; v_resp_err = if_a.respErr;
            v_resp_data = if_a.respData; v_addr = if_a.dataBusAddr; v_ren = if_a.dataBusReadEn;
            v_wen = if_a.dataBusWriteEn; v_mask = {4'b0, if_a.dataBusWriteMask};
            v_wdata = {32'b0, if_a.dataBusWriteData};
         end
         1: begin
            v_ready = if_b.reqReady; v_resp_valid = if_b.respValid; v_resp_err = if_b.respErr;
            v_resp_data = if_b.respData; v_addr = if_b.dataBusAddr; v_ren = if_b.dataBusReadEn;
            v_wen = if_b.dataBusWriteEn; v_mask = {4'b0, if_b.dataBusWriteMask};
            v_wdata = {32'b0, if_b.dataBusWriteData};
         end
         default: begin
            v_ready = if_c.reqReady; v_resp_valid = if_c.respValid; v_resp_err = if_c.respErr;
            v_resp_data = if_c.respData; v_addr = if_c.dataBusAddr; v_ren = if_c.dataBusReadEn;
            v_wen = if_c.dataBusWriteEn; v_mask = if_c.dataBusWriteMask; v_wdata = if_c.dataBusWriteData;
         end
      endcase
   end

   always @(negedge clk) if (if_b.dataBusReadEn || if_b.dataBusWriteEn) en_b_count++;

   // Core + bus driver: issue one request, play a bus with gw idle cycles before
   // each grant and rw extra cycles before each rvalid, record what was seen.
   task automatic run_access(input int s, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int gw, input int rw,
                             input logic [63:0] rd0, input logic [63:0] rd1);
      int gcnt, rvcnt, rvbeat;
      bit rvpend, held, done;
      logic [31:0] h_addr;
      logic [7:0]  h_mask;
      logic [63:0] h_wdata;
      logic        h_wen;
      sel = s;
      obs_beats = 0; obs_lat = -1; obs_err = 1'bx; obs_data = 'x;
      obs_stable = 1; obs_idle_zero = 1; obs_en_seen = 0;
      gcnt = 0; rvcnt = 0; rvbeat = 0; rvpend = 0; held = 0; done = 0;
      h_addr = '0; h_mask = '0; h_wdata = '0; h_wen = 0;
      @(negedge clk);
      obs_ready0 = v_ready;
      req_valid = 1; req_write = wr; req_f3 = f3; req_addr = addr; req_wdata = wd;
      bus_gnt = 0; bus_rvalid = $urandom_range(0, 1); bus_rdata = {$urandom, $urandom};
      for (int c = 1; c <= 80 && !done; c++) begin
         @(negedge clk);
         req_valid = 0; req_write = $urandom_range(0, 1); req_f3 = 3'($urandom);
         req_addr = $urandom; req_wdata = $urandom;
         bus_gnt = 0; bus_rvalid = 0; bus_rdata = {$urandom, $urandom};
         if (rvpend) begin
            if (rvcnt == 0) begin
               bus_rvalid = 1; bus_rdata = (rvbeat == 0) ? rd0 : rd1; rvpend = 0;
            end else rvcnt--;
         end else bus_rvalid = ($urandom_range(0, 3) == 0);
         if (v_resp_valid) begin
            done = 1; obs_lat = c; obs_err = v_resp_err; obs_data = v_resp_data;
         end
         if (v_ren || v_wen) begin
            obs_en_seen = 1;
            if (held && (v_addr !== h_addr || v_mask !== h_mask || v_wdata !== h_wdata || v_wen !== h_wen))
               obs_stable = 0;
            if (!held) begin
               held = 1; h_addr = v_addr; h_mask = v_mask; h_wdata = v_wdata; h_wen = v_wen;
            end
            if (gcnt < gw) gcnt++;
            else begin
               bus_gnt = 1;
               if (obs_beats < 2) begin
                  obs_addr[obs_beats] = v_addr; obs_mask[obs_beats] = v_mask;
                  obs_wdata[obs_beats] = v_wdata; obs_wen[obs_beats] = v_wen;
               end
               if (v_ren) begin rvpend = 1; rvcnt = rw; rvbeat = obs_beats; end
               obs_beats++; gcnt = 0; held = 0;
            end
         end else if (v_addr !== '0 || v_mask !== '0 || v_wdata !== '0) obs_idle_zero = 0;
      end
      bus_gnt = 0; bus_rvalid = 0;
   endtask

   // Reference: place the access byte by byte into a two-beat window.
   task automatic model_access(input int s, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input int gw, input int rw,
                               input logic [63:0] rd0, input logic [63:0] rd1);
      int bb, size, off, k;
      bit spl;
      logic [31:0] base, v;
      logic [7:0] byte_v;
      bb = (s == 2) ? 8 : 4;
      case (f3)
         FUNCT3_BYTE, FUNCT3_BYTE_U:         size = 1;
         FUNCT3_HALFWORD, FUNCT3_HALFWORD_U: size = 2;
         FUNCT3_WORD:                        size = 4;
         default:                            size = 0;
      endcase
      off = int'(addr % bb);
      spl = (off + size) > bb;
      exp_err = (size == 0) || (spl && (s == 1));
      exp_beats = exp_err ? 0 : (spl ? 2 : 1);
      base = addr - 32'(off);
      exp_addr[0] = base;
      exp_addr[1] = base + 32'(bb);
      exp_mask[0] = '0; exp_mask[1] = '0; exp_wdata[0] = '0; exp_wdata[1] = '0;
      for (int p = 0; p < 2 * bb; p++) begin
         k = p - off;
         if (k >= 0 && k < 4) exp_wdata[p / bb][8 * (p % bb) +: 8] = wd[8 * k +: 8];
         if (k >= 0 && k < size) exp_mask[p / bb][p % bb] = 1'b1;
      end
      v = '0;
      for (int i = 0; i < size; i++) begin
         byte_v = (off + i < bb) ? rd0[8 * (off + i) +: 8] : rd1[8 * (off + i - bb) +: 8];
         v[8 * i +: 8] = byte_v;
      end
      if (f3 == FUNCT3_BYTE && v[7]) v[31:8] = '1;
      if (f3 == FUNCT3_HALFWORD && v[15]) v[31:16] = '1;
      exp_data = (exp_err || wr) ? 32'd0 : v;
      exp_lat = exp_err ? 1 : 1 + exp_beats * (wr ? gw + 1 : gw + rw + 2);
   endtask

   task automatic test_reset;
      resetN = 0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         checks++;
         if ({v_ready, v_resp_valid, v_ren, v_wen} !== 4'b1000 || v_addr !== '0 || v_mask !== '0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: got rdy/rv/ren/wen=%b%b%b%b addr=%h mask=%h expected 1000/0/0",
                     s, v_ready, v_resp_valid, v_ren, v_wen, v_addr, v_mask);
         end
      end
      resetN = 1;
      @(negedge clk);
      sel = 0; #1;
      checks++;
      if (v_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", v_ready); end
   endtask

   task automatic test_directed;
      int en_saved;
      // LB 0x1003, read 0x80FFFF00
      run_access(0, 0, FUNCT3_BYTE, 32'h1003, 32'h0, 0, 0, 64'h80FF_FF00, 64'h0);
      checks++; if (obs_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", obs_data); end
      checks++; if (obs_lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", obs_lat); end
      checks++; if (obs_beats !== 1 || obs_addr[0] !== 32'h1000) begin errors++; $display("FAIL lb_beat: got %0d beats addr %h expected 1 beat at 00001000", obs_beats, obs_addr[0]); end
      // SW 0xAABBCCDD at 0x2002, split
      run_access(0, 1, FUNCT3_WORD, 32'h2002, 32'hAABB_CCDD, 0, 0, 64'h0, 64'h0);
      checks++;
      if (obs_beats !== 2 || obs_addr[0] !== 32'h2000 || obs_mask[0] !== 8'hC || obs_wdata[0] !== 64'hCCDD_0000) begin
         errors++; $display("FAIL sw_beat0: got %0d beats %h/%h/%h expected 2 beats 00002000/0c/ccdd0000", obs_beats, obs_addr[0], obs_mask[0], obs_wdata[0]);
      end
      checks++;
      if (obs_addr[1] !== 32'h2004 || obs_mask[1] !== 8'h3 || obs_wdata[1] !== 64'h0000_AABB) begin
         errors++; $display("FAIL sw_beat1: got %h/%h/%h expected 00002004/03/0000aabb", obs_addr[1], obs_mask[1], obs_wdata[1]);
      end
      @(negedge clk);
      checks++; if (v_resp_valid !== 1'b0 || v_ready !== 1'b1) begin errors++; $display("FAIL sw_single_resp: got rv=%b rdy=%b expected 0/1", v_resp_valid, v_ready); end
      // LW at 0x2002 across two beats
      run_access(0, 0, FUNCT3_WORD, 32'h2002, 32'h0, 0, 0, 64'h1122_3344, 64'h5566_7788);
      checks++; if (obs_data !== 32'h7788_1122) begin errors++; $display("FAIL lw_split_data: got %h expected 77881122", obs_data); end
      checks++; if (obs_lat !== 5) begin errors++; $display("FAIL lw_split_latency: got %0d expected 5", obs_lat); end
      // LHU at 0xFFFFFFFF wraps to beat1 at 0
      run_access(0, 0, FUNCT3_HALFWORD_U, 32'hFFFF_FFFF, 32'h0, 1, 1, 64'hAB00_0000, 64'h0000_00CD);
      checks++; if (obs_beats !== 2 || obs_addr[0] !== 32'hFFFF_FFFC || obs_addr[1] !== 32'h0) begin errors++; $display("FAIL lhu_wrap_addr: got %0d beats %h %h expected fffffffc 00000000", obs_beats, obs_addr[0], obs_addr[1]); end
      checks++; if (obs_data !== 32'h0000_CDAB) begin errors++; $display("FAIL lhu_wrap_data: got %h expected 0000cdab", obs_data); end
      // Same access without split support
      en_saved = en_b_count;
      run_access(1, 0, FUNCT3_HALFWORD_U, 32'hFFFF_FFFF, 32'h0, 0, 0, 64'h0, 64'h0);
      @(negedge clk);
      checks++; if (obs_err !== 1'b1 || obs_lat !== 1) begin errors++; $display("FAIL lhu_noalign_err: got err=%b lat=%0d expected 1/1", obs_err, obs_lat); end
      checks++; if (en_b_count !== en_saved) begin errors++; $display("FAIL lhu_noalign_no_bus: got %0d enable cycles expected 0", en_b_count - en_saved); end
      // SH on 8-byte bus
      run_access(2, 1, FUNCT3_HALFWORD, 32'h3006, 32'h0000_BEEF, 0, 0, 64'h0, 64'h0);
      checks++;
      if (obs_beats !== 1 || obs_addr[0] !== 32'h3000 || obs_mask[0] !== 8'hC0 || obs_wdata[0] !== 64'hBEEF_0000_0000_0000) begin
         errors++; $display("FAIL sh_bus8: got %0d beats %h/%h/%h expected 1 beat 00003000/c0/beef000000000000", obs_beats, obs_addr[0], obs_mask[0], obs_wdata[0]);
      end
      // Illegal funct3
      run_access(0, 0, 3'b011, 32'h4000, 32'h0, 0, 0, 64'h0, 64'h0);
      checks++; if (obs_err !== 1'b1 || obs_lat !== 1 || obs_data !== 32'd0 || obs_en_seen !== 1'b0) begin
         errors++; $display("FAIL illegal_funct3: got err=%b lat=%0d data=%h bus=%b expected 1/1/0/0", obs_err, obs_lat, obs_data, obs_en_seen);
      end
   endtask

   task automatic test_reset_mid;
      sel = 0;
      @(negedge clk);
      req_valid = 1; req_write = 0; req_f3 = FUNCT3_WORD; req_addr = 32'h1000; req_wdata = 32'h0; bus_gnt = 0; bus_rvalid = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_valid = 0; req_addr = $urandom;
         checks++;
         if (v_ren !== 1'b1 || v_addr !== 32'h1000) begin errors++; $display("FAIL held_request cyc%0d: got ren=%b addr=%h expected 1/00001000", c, v_ren, v_addr); end
      end
      @(negedge clk);
      resetN = 0;
      @(negedge clk);
      resetN = 1;
      checks++;
      if (v_ready !== 1'b1 || v_ren !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: got rdy=%b ren=%b expected 1/0", v_ready, v_ren); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus_rvalid = 1; bus_rdata = {$urandom, $urandom};
         checks++;
         if (v_resp_valid !== 1'b0 || v_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_no_resp cyc%0d: got rv=%b rdy=%b expected 0/1", c, v_resp_valid, v_ready); end
      end
      bus_rvalid = 0;
   endtask

   task automatic test_random_back_to_back;
      logic [2:0] f3_tab [8] = '{FUNCT3_BYTE, FUNCT3_HALFWORD, FUNCT3_WORD, FUNCT3_BYTE_U, FUNCT3_HALFWORD_U, 3'b011, 3'b110, 3'b111};
      int s, gw, rw, idx;
      bit wr;
      logic [2:0] f3;
      logic [31:0] addr, wd;
      logic [63:0] rd0, rd1;
      for (int i = 0; i < 150; i++) begin
         s = $urandom_range(0, 2); wr = 1'($urandom_range(0, 1));
         idx = $urandom_range(0, 11); f3 = (idx < 10) ? f3_tab[idx % 5] : f3_tab[5 + (idx - 10)];
         addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
         wd = $urandom; gw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
         rd0 = {$urandom, $urandom}; rd1 = {$urandom, $urandom};
         if (s != 2) begin rd0[63:32] = '0; rd1[63:32] = '0; end
         model_access(s, wr, f3, addr, wd, gw, rw, rd0, rd1);
         run_access(s, wr, f3, addr, wd, gw, rw, rd0, rd1);
         checks++; if (obs_ready0 !== 1'b1) begin errors++; $display("FAIL rnd%0d ready: got %b expected 1", i, obs_ready0); end
         checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL rnd%0d latency: got %0d expected %0d", i, obs_lat, exp_lat); end
         checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rnd%0d err: got %b expected %b", i, obs_err, exp_err); end
         checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL rnd%0d data: got %h expected %h", i, obs_data, exp_data); end
         checks++; if (obs_beats !== exp_beats) begin errors++; $display("FAIL rnd%0d beats: got %0d expected %0d", i, obs_beats, exp_beats); end
         checks++; if (obs_en_seen !== (exp_beats != 0)) begin errors++; $display("FAIL rnd%0d bus_used: got %b expected %b", i, obs_en_seen, exp_beats != 0); end
         checks++; if (obs_stable !== 1'b1 || obs_idle_zero !== 1'b1) begin errors++; $display("FAIL rnd%0d bus_hold: got stable=%b idle_zero=%b expected 1/1", i, obs_stable, obs_idle_zero); end
         for (int b = 0; b < exp_beats && b < obs_beats; b++) begin
            checks++;
            if (obs_addr[b] !== exp_addr[b] || obs_wen[b] !== wr) begin errors++; $display("FAIL rnd%0d beat%0d_addr: got %h wen=%b expected %h wen=%b", i, b, obs_addr[b], obs_wen[b], exp_addr[b], wr); end
            if (wr) begin
               checks++;
               if (obs_mask[b] !== exp_mask[b] || obs_wdata[b] !== exp_wdata[b]) begin
                  errors++; $display("FAIL rnd%0d beat%0d_store: got %h/%h expected %h/%h", i, b, obs_mask[b], obs_wdata[b], exp_mask[b], exp_wdata[b]);
               end
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      sel = 0; resetN = 0;
      req_valid = 0; req_write = 0; req_f3 = '0; req_addr = '0; req_wdata = '0;
      bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
      test_reset();
      test_directed();
      test_reset_mid();
      test_random_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_split_interface.md
# dm_split_interface

Parametrised data-memory interface for the loopyV core, sitting between the MEM/WB stages and the data bus. It adds a valid/ready request handshake and a granted, variable-latency bus, plus a configurable bus width. When enabled, it splits misaligned byte/halfword/word accesses that cross a bus-word boundary into two bus beats. It stalls the core via `reqReady` until the access completes, then returns sign- or zero-extended load data or a store acknowledgement.

## Interface
- `BUS_BYTES`, default 4: data-bus width in bytes, 4 or 8.
- `MISALIGNED_EN`, default 1: 1 splits boundary-crossing accesses; 0 reports them as errors.
- `clk` input, 1 bit: clock. All logic is on the rising edge.
- `resetN` input, 1 bit: reset, synchronous and active-low.
- `reqValid` input, 1 bit: core request valid.
- `reqReady` output, 1 bit: block idle and able to accept a request.
- `reqWrite` input, 1 bit: 1 = store, 0 = load.
- `reqFunct3` input, 3 bits: access size/sign, using the FUNCT3_* encodings.
- `reqAddr` input, 32 bits: byte address.
- `reqWData` input, 32 bits: store data, right-justified.
- `respValid` output, 1 bit: one-cycle completion pulse.
- `respErr` output, 1 bit: completion is an error (illegal funct3, or misaligned access with MISALIGNED_EN=0). Qualified by `respValid`.
- `respData` output, 32 bits: extended load data. It is 0 for stores and errors.
- `dataBusAddr` output, 32 bits: bus-word-aligned address.
- `dataBusReadEn` output, 1 bit: read request.
- `dataBusWriteEn` output, 1 bit: write request.
- `dataBusWriteMask` output, BUS_BYTES bits: byte enables.
- `dataBusWriteData` output, 8*BUS_BYTES bits: lane-aligned store data.
- `dataBusGnt` input, 1 bit: request accepted this cycle.
- `dataBusRValid` input, 1 bit: read data valid. Returned in order, at least 1 cycle after the granting cycle.
- `dataBusReadData` input, 8*BUS_BYTES bits: read data.

## Operation
- **Acceptance:** the request is accepted when `reqValid && reqReady`. Address, funct3, write flag and wdata are registered at acceptance.
- **Derived fields:**
  - size = 1, 2 or 4 bytes for BYTE/BYTE_U, HALFWORD/HALFWORD_U and WORD respectively.
  - offset = addr mod BUS_BYTES.
  - split = (offset + size > BUS_BYTES).
- **Beat addresses:**
  - beat0 = addr with the low log2(BUS_BYTES) bits cleared.
  - beat1 = beat0 + BUS_BYTES, wrapping modulo 2^32, so 0xFFFFFFFF + 1 wraps to 0.
- **Store shaping:**
  - The 2*BUS_BYTES-bit mask is ((1<<size)-1) << offset.
  - The 2*8*BUS_BYTES-bit data is wdata << (8*offset).
  - The low halves go on beat0 and the high halves on beat1.
- **Load assembly:**
  - Beat0 data is captured on its rvalid.
  - The final word is ({beat1, beat0} >> 8*offset), with beat1 = 0 if there is no split.
  - It is then sign-extended (BYTE, HALFWORD) or zero-extended (BYTE_U, HALFWORD_U). WORD passes through.
- **FSM states:** IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
  - IDLE → REQ0 on a legal acceptance. IDLE → DONE (error) on an illegal funct3 or a disallowed misaligned access; no bus request is issued.
  - REQ0: beat0 request held until `dataBusGnt`. On grant: a load goes to RSP0; a store goes to REQ1 if split, otherwise DONE.
  - RSP0: on `dataBusRValid`, capture the data and go to REQ1 if split, otherwise DONE.
  - REQ1: beat1 request held until grant. Then a load goes to RSP1 and a store goes to DONE.
  - RSP1: on rvalid, capture the data and go to DONE.
  - DONE: `respValid` = 1 for one cycle, then IDLE.
- **Output rules:**
  - Bus request outputs are driven only in REQ0/REQ1. Otherwise enables, mask, data and addr are 0.
  - `reqReady` = (state == IDLE).
  - `dataBusRValid` outside RSP0/RSP1 is ignored.
- **Reset:** outputs become `reqReady`=1 and all others 0; state goes to IDLE. A reset mid-access abandons the access with no response. The bus shares `resetN`.

## Timing
- Zero-wait aligned load (grant in the REQ0 cycle, rvalid 1 cycle later):
  - cycle 0: accept
  - cycle 1: REQ0
  - cycle 2: RSP0
  - cycle 3: `respValid`
  - cycle 4: `reqReady` high again
- Aligned store: accept in cycle 0, `respValid` in cycle 2.
- Each split beat adds 1 cycle (store) or 2 cycles (load), plus any grant/rvalid wait.
- Errors: `respValid` with `respErr` in the cycle after acceptance.
- `respData`/`respErr` are valid only in the DONE cycle.

## Structure
- **Package `loopyV_data_types`:**
  - Existing FUNCT3_* constants are reused.
  - Add the `dm_state_t` enum (six states above).
  - Add a function returning the access size from funct3 (0 = illegal).
- **Sub-module `dm_lane_align` (combinational):**
  - Inputs: funct3, offset, wdata, {beat1, beat0} read data.
  - Outputs: 2-beat mask, 2-beat write data, extended load result.
- The top module holds the FSM, request registers and beat capture.

## Test plan
- BUS_BYTES=4: LB at 0x1003, read word 0x80FF_FF00, zero-wait → one beat at 0x1000, `respData`=0xFFFF_FF80, `respValid` at cycle 3.
- SW 0xAABBCCDD at 0x2002 → beat0 addr 0x2000 mask 0b1100 data 0xCCDD_0000; beat1 addr 0x2004 mask 0b0011 data 0x0000_AABB; one `respValid`.
- LW at 0x2002, beats 0x1122_3344 / 0x5566_7788 → `respData`=0x7788_1122.
- LHU at 0xFFFF_FFFF with split → beat1 addr 0x0000_0000.
- Same LHU with MISALIGNED_EN=0 → `respErr`=1, no bus enable ever asserted.
- `dataBusGnt` withheld 3 cycles in REQ0, then `resetN` low for one cycle → request held stable while waiting; after reset, state IDLE, `reqReady`=1, no `respValid`.
- BUS_BYTES=8: SH 0xBEEF at 0x3006 → single beat, mask 0xC0.
- funct3=3'b011 → error response next cycle.
